// File: rtl/cache_control.sv
// ============================================================================
// cache_control
// Sequencing FSM for a direct-mapped write-back L1 cache, with hit/miss counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   hit,
  input  logic                   dirty,
  input  logic                   pmem_resp,
  output logic                   mem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic                   data_write,
  output logic                   tag_write,
  output logic                   valid_write,
  output logic                   dirty_write,
  output logic                   dirty_in,
  output logic                   datain_sel,
  output logic                   pmem_addr_sel,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_miss;
  logic                   w_req;
  logic                   r_retry;
  logic [COUNT_WIDTH-1:0] r_hit_count;
  logic [COUNT_WIDTH-1:0] r_miss_count;

  assign w_req      = mem_read | mem_write;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Outputs are forced low while reset is held, independent of state.
  always_comb begin
    w_next        = r_state;
    w_miss        = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    data_write    = 1'b0;
    tag_write     = 1'b0;
    valid_write   = 1'b0;
    dirty_write   = 1'b0;
    dirty_in      = 1'b0;
    datain_sel    = 1'b0;
    pmem_addr_sel = 1'b0;
    if (rst_n) begin
      case (r_state)
        CHECK: begin
          if (w_req) begin
            if (hit) begin
              mem_resp = 1'b1;
              if (mem_write) begin
                data_write  = 1'b1;
                datain_sel  = 1'b1;
                dirty_write = 1'b1;
                dirty_in    = 1'b1;
              end
            end else begin
              w_miss = 1'b1;
              w_next = dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) w_next = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            data_write  = 1'b1;
            tag_write   = 1'b1;
            valid_write = 1'b1;
            dirty_write = 1'b1;
            w_next      = CHECK;
          end
        end
        default: w_next = CHECK;
      endcase
    end
  end

  // retry marks a request that already missed so its final hit is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CHECK;
      r_retry      <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss)
        r_retry <= 1'b1;
      else if (mem_resp)
        r_retry <= 1'b0;
      if (w_miss && !(&r_miss_count))
        r_miss_count <= r_miss_count + c_count_one;
      if (mem_resp && !r_retry && !(&r_hit_count))
        r_hit_count <= r_hit_count + c_count_one;
    end
  end

endmodule

`default_nettype wire

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the direct-mapped, write-back L1 cache. It sits between the CPU memory port and physical memory. It drives the write enables and mux selects of the data, tag, valid and dirty arrays, which are 8 sets with asynchronous read and a synchronous write on `clk`. It also keeps first-look hit/miss performance counters.

## Interface
- `COUNT_WIDTH`, 16, width of the saturating hit/miss counters.
- `clk`  in  1  clock; arrays and FSM share this edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`. Never asserted together with `mem_read`.
- `hit`  in  1  datapath: valid[index] & (tag[index] == addr tag), combinational from the arrays.
- `dirty`  in  1  datapath: dirty[index].
- `pmem_resp`  in  1  physical memory done, 1-cycle pulse.
- `mem_resp`  out  1  CPU request complete.
- `pmem_read`  out  1  line fill request; held until `pmem_resp`.
- `pmem_write`  out  1  line writeback request; held until `pmem_resp`.
- `data_write`  out  1  data array write enable.
- `tag_write`  out  1  tag array write enable.
- `valid_write`  out  1  valid array write enable. Write value is always 1.
- `dirty_write`  out  1  dirty array write enable.
- `dirty_in`  out  1  value written to the dirty array.
- `datain_sel`  out  1  data array input: 0 = pmem line, 1 = line merged with CPU write data and byte enables.
- `pmem_addr_sel`  out  1  pmem address: 0 = CPU address line, 1 = {tag[index], index} (victim).
- `hit_count`  out  `COUNT_WIDTH`  first-look hits.
- `miss_count`  out  `COUNT_WIDTH`  misses.

## Operation
- States: CHECK (reset state), WRITEBACK, ALLOCATE.
- Control outputs are combinational from state and inputs. Every output not listed for a state/condition is 0.
- CHECK, no request: hold state.
- CHECK, request & `hit`:
  - `mem_resp`=1.
  - Write requests additionally set `data_write`=1, `datain_sel`=1, `dirty_write`=1 and `dirty_in`=1.
  - Remain in CHECK.
- CHECK, request & !`hit` & `dirty`: next state is WRITEBACK.
- CHECK, request & !`hit` & !`dirty`: next state is ALLOCATE.
- WRITEBACK:
  - `pmem_write`=1, `pmem_addr_sel`=1.
  - On `pmem_resp`, go to ALLOCATE. Otherwise hold.
- ALLOCATE:
  - `pmem_read`=1, `pmem_addr_sel`=0.
  - On `pmem_resp`: `data_write`=1, `datain_sel`=0, `tag_write`=1, `valid_write`=1, `dirty_write`=1, `dirty_in`=0, and go to CHECK.
  - Otherwise hold.
- After a fill, the retry in CHECK hits. A write then merges and sets the line dirty.
- `retry` flag (internal):
  - Set on every transition out of CHECK on a miss.
  - Cleared on `mem_resp`.
- `miss_count` increments on each transition CHECK→WRITEBACK or CHECK→ALLOCATE.
- `hit_count` increments on `mem_resp` when `retry`=0.
- Both counters saturate at all-ones.
- A CPU request that deasserts mid-miss is not a legal CPU behaviour. The FSM still completes the pmem transaction in progress and any ALLOCATE that follows, then returns to CHECK. `mem_resp` is not asserted unless a request is present in CHECK.

## Timing
- Reset (`rst_n`=0, async):
  - State goes to CHECK and `retry` to 0.
  - Both counters go to 0.
  - All control outputs are 0 for as long as `rst_n` is low, regardless of inputs.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE abandons the transaction. `pmem_read`/`pmem_write` drop immediately.
- Hit latency:
  - `mem_resp` in the same cycle the request is seen with `hit`=1.
  - A hit write commits to the arrays at the same rising edge.
- Clean miss: the ALLOCATE cycles, then the hit cycle. Total = 1 (CHECK) + pmem latency + 1.
- Dirty miss: adds the WRITEBACK duration before ALLOCATE.
- Array writes in ALLOCATE occur at the edge where `pmem_resp`=1. On the next cycle `hit` reflects the new tag/valid.
- Back-to-back hits: one `mem_resp` per cycle. Each cycle with request & `hit` counts as one hit.
- Counter updates are registered; new values are visible the cycle after the event.
- A `pmem_resp` arriving in CHECK is ignored.

## Test plan
- Reset: assert `rst_n`=0 with `mem_read`=1 and `hit`=1 → `mem_resp`=0, all enables 0, `hit_count`=`miss_count`=0. Release reset → `mem_resp`=1 the same cycle, and `hit_count`=1 the next cycle.
- Clean read miss: `mem_read`=1, `hit`=0, `dirty`=0, with `pmem_resp` pulsed 3 cycles after `pmem_read` rises; raise `hit` after the fill edge.
  - `pmem_read` stays high 4 cycles.
  - `tag_write`/`valid_write`/`data_write`=1 with `dirty_in`=0 in the `pmem_resp` cycle.
  - `mem_resp` 1 cycle later.
  - `miss_count`=1, `hit_count`=0.
- Dirty write miss: `mem_write`=1, `hit`=0, `dirty`=1.
  - `pmem_write`=1 with `pmem_addr_sel`=1 until `pmem_resp`.
  - Then `pmem_read`=1 with `pmem_addr_sel`=0.
  - The final CHECK cycle shows `data_write`=1, `datain_sel`=1, `dirty_in`=1 and `mem_resp`=1.
- 5 back-to-back read hits → `mem_resp`=1 for 5 consecutive cycles, `hit_count`=5, no pmem activity.
- Counter saturation with `COUNT_WIDTH`=4: 20 hits → `hit_count`=15 and stays at 15.
- Reset mid-ALLOCATE: `rst_n` low while `pmem_read`=1 → `pmem_read`=0 immediately. After release, the state is CHECK and a stray `pmem_resp` pulse causes no array writes.
